instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 196 +++++++++++++++++++
 tb/tb_instruction_fetch.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Instruction fetch unit. Holds a 256x8 program memory, issues
//               one synchronous read at a time on behalf of the programme
//               counter and queues the fetched words (with their addresses)
//               in a FIFO_DEPTH-entry prefetch buffer whose head is presented
//               to the decoder through registered outputs.
//               Optional feature macro: IFU_PARITY_EN (even parity per word,
//               sticky par_err output).
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic       clk,
    input  logic       power,
    input  logic       prog_we,
    input  logic [7:0] prog_addr,
    input  logic [7:0] prog_data,
    input  logic [7:0] add,
    input  logic       add_valid,
    output logic [7:0] instr,
    output logic [7:0] instr_addr,
    output logic       instr_valid,
    input  logic       instr_ready,
`ifdef IFU_PARITY_EN
    output logic       par_err,
`endif
    output logic       stall
);

    localparam int             c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int             c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W:0] c_DEPTH = (c_CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_issue;
    logic                 w_flush;
    logic                 w_stall;

    // Program memory and the single outstanding read
    logic [7:0]           r_mem [256];
    logic [7:0]           r_rd_data;
    logic [7:0]           r_rd_addr;
    logic                 r_inflight;

    // Prefetch buffer storage; the head word is copied into instr/instr_addr
    logic [7:0]           r_buf_data [FIFO_DEPTH];
    logic [7:0]           r_buf_addr [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_st_count;

    logic [c_CNT_W-1:0]   w_count;
    logic [c_CNT_W:0]     w_occ;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_load;

    // Words held = stored entries plus the one sitting on the output register
    assign w_count = r_st_count + {{c_PTR_W{1'b0}}, instr_valid};
    assign w_occ   = {1'b0, w_count} + {{c_CNT_W{1'b0}}, r_inflight};
    assign w_push  = r_inflight;
    assign w_pop   = instr_valid & instr_ready;
    // Refill the output register whenever it is empty or being consumed
    assign w_load  = (~instr_valid | instr_ready) & (r_st_count != '0);
    assign stall   = w_stall;

    // State register
    always_ff @(posedge clk or negedge power) begin
        if (!power) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, stall and read-issue decode
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b1;
        w_issue      = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!prog_we && add_valid) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_stall = (w_occ >= c_DEPTH);
                if (prog_we) begin
                    // A program load invalidates everything prefetched so far
                    w_flush      = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_issue = add_valid & ~w_stall;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Program memory: write port and synchronous read (old data on collision)
    always_ff @(posedge clk) begin
        if (prog_we) begin
            r_mem[prog_addr] <= prog_data;
        end
        if (w_issue) begin
            r_rd_data <= r_mem[add];
        end
    end

    // Buffer storage write; dropped when a flush lands on the same edge
    always_ff @(posedge clk) begin
        if (w_push && !w_flush) begin
            r_buf_data[r_wr_ptr] <= r_rd_data;
            r_buf_addr[r_wr_ptr] <= r_rd_addr;
        end
    end

    // Read tracking, buffer pointers/count and the decoder-facing head
    always_ff @(posedge clk or negedge power) begin
        if (!power) begin
            r_inflight  <= 1'b0;
            r_rd_addr   <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_st_count  <= '0;
            instr       <= '0;
            instr_addr  <= '0;
            instr_valid <= 1'b0;
        end else if (w_flush) begin
            r_inflight  <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_st_count  <= '0;
            instr_valid <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_rd_addr <= add;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                instr       <= r_buf_data[r_rd_ptr];
                instr_addr  <= r_buf_addr[r_rd_ptr];
                instr_valid <= 1'b1;
                r_rd_ptr    <= r_rd_ptr + 1'b1;
            end else if (w_pop) begin
                instr_valid <= 1'b0;
            end
            r_st_count <= r_st_count + {{c_PTR_W{1'b0}}, w_push}
                                     - {{c_PTR_W{1'b0}}, w_load};
        end
    end

`ifdef IFU_PARITY_EN
    logic r_mem_par [256];
    logic r_rd_par;

    // Even parity bit stored alongside each word, read with it
    always_ff @(posedge clk) begin
        if (prog_we) begin
            r_mem_par[prog_addr] <= ^prog_data;
        end
        if (w_issue) begin
            r_rd_par <= r_mem_par[add];
        end
    end

    // Sticky error, checked as the word enters the buffer
    always_ff @(posedge clk or negedge power) begin
        if (!power) begin
            par_err <= 1'b0;
        end else if (w_flush) begin
            par_err <= 1'b0;
        end else if (w_push && ((^r_rd_data) != r_rd_par)) begin
            par_err <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Self-checking bench for instruction_fetch (FIFO_DEPTH=2).
//               Cycle table for the basic stream, then directed sequences for
//               back-pressure, address wrap, async reset and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    logic       clk;
    logic       power;
    logic       prog_we;
    logic [7:0] prog_addr;
    logic [7:0] prog_data;
    logic [7:0] add;
    logic       add_valid;
    logic [7:0] instr;
    logic [7:0] instr_addr;
    logic       instr_valid;
    logic       instr_ready;
    logic       stall;
`ifdef IFU_PARITY_EN
    logic       par_err;
`endif

    instruction_fetch #(.FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .power       (power),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .add         (add),
        .add_valid   (add_valid),
        .instr       (instr),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
`ifdef IFU_PARITY_EN
        .par_err     (par_err),
`endif
        .stall       (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [7:0] a;
    } word_t;

    typedef struct {
        logic       av;
        logic [7:0] ad;
        logic       rdy;
        logic       ev;
        logic [7:0] ei;
        logic [7:0] ea;
        logic       es;
    } vec_t;

    int         checks;
    int         failures;
    int         issues;
    logic [7:0] pc;
    word_t      got[$];
    vec_t       tbl[10];

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", nm, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        add_valid = 1'b0;
        @(posedge clk);
        #1;
        prog_we = 1'b0;
    endtask

    // Reset asserted and released between edges; ends at a falling edge
    task automatic do_reset();
        @(posedge clk);
        #3;
        power       = 1'b0;
        prog_we     = 1'b0;
        add_valid   = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk);
        power = 1'b1;
    endtask

    // One cycle of a simple programme counter: it advances only when a read
    // was accepted, and every handshaked word is logged.
    task automatic run_cycle(input logic av, input logic rdy);
        logic       pre_stall;
        logic       pre_valid;
        logic [7:0] pd;
        logic [7:0] pa;
        add         = pc;
        add_valid   = av;
        instr_ready = rdy;
        prog_we     = 1'b0;
        pre_stall   = stall;
        pre_valid   = instr_valid;
        pd          = instr;
        pa          = instr_addr;
        @(posedge clk);
        #1;
        if (av && !pre_stall) begin
            pc = pc + 8'd1;
            issues++;
        end
        if (pre_valid && rdy) begin
            got.push_back('{d: pd, a: pa});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        issues      = 0;
        pc          = 8'h00;
        power       = 1'b0;
        prog_we     = 1'b0;
        prog_addr   = 8'h00;
        prog_data   = 8'h00;
        add         = 8'h00;
        add_valid   = 1'b0;
        instr_ready = 1'b0;

        // Cycle table: inputs sampled on one edge, outputs checked after it
        tbl[0] = '{av:1'b1, ad:8'h00, rdy:1'b1, ev:1'b0, ei:8'h00, ea:8'h00, es:1'b0};
        tbl[1] = '{av:1'b1, ad:8'h00, rdy:1'b1, ev:1'b0, ei:8'h00, ea:8'h00, es:1'b0};
        tbl[2] = '{av:1'b1, ad:8'h01, rdy:1'b1, ev:1'b0, ei:8'h00, ea:8'h00, es:1'b1};
        tbl[3] = '{av:1'b1, ad:8'h02, rdy:1'b1, ev:1'b1, ei:8'h11, ea:8'h00, es:1'b1};
        tbl[4] = '{av:1'b1, ad:8'h02, rdy:1'b1, ev:1'b1, ei:8'h22, ea:8'h01, es:1'b0};
        tbl[5] = '{av:1'b1, ad:8'h02, rdy:1'b1, ev:1'b0, ei:8'h00, ea:8'h00, es:1'b0};
        tbl[6] = '{av:1'b1, ad:8'h03, rdy:1'b1, ev:1'b0, ei:8'h00, ea:8'h00, es:1'b1};
        tbl[7] = '{av:1'b0, ad:8'h04, rdy:1'b1, ev:1'b1, ei:8'h33, ea:8'h02, es:1'b1};
        tbl[8] = '{av:1'b0, ad:8'h04, rdy:1'b1, ev:1'b1, ei:8'h44, ea:8'h03, es:1'b0};
        tbl[9] = '{av:1'b0, ad:8'h04, rdy:1'b1, ev:1'b0, ei:8'h00, ea:8'h00, es:1'b0};

        // Reset state
        #12;
        chk8("rst_instr", instr, 8'h00);
        chk8("rst_instr_addr", instr_addr, 8'h00);
        chk1("rst_valid", instr_valid, 1'b0);
        chk1("rst_stall", stall, 1'b1);
`ifdef IFU_PARITY_EN
        chk1("rst_par_err", par_err, 1'b0);
`endif
        @(negedge clk);
        power = 1'b1;

        load(8'h00, 8'h11);
        load(8'h01, 8'h22);
        load(8'h02, 8'h33);
        load(8'h03, 8'h44);
        load(8'hFE, 8'hA1);
        load(8'hFF, 8'hB2);

        // Basic stream 0..3 with latency and stall pattern
        for (int i = 0; i < 10; i++) begin
            add         = tbl[i].ad;
            add_valid   = tbl[i].av;
            instr_ready = tbl[i].rdy;
            @(posedge clk);
            #1;
            chk1($sformatf("tbl%0d_valid", i), instr_valid, tbl[i].ev);
            chk1($sformatf("tbl%0d_stall", i), stall, tbl[i].es);
            if (tbl[i].ev) begin
                chk8($sformatf("tbl%0d_instr", i), instr, tbl[i].ei);
                chk8($sformatf("tbl%0d_addr", i), instr_addr, tbl[i].ea);
            end
        end

        // Back-pressure: two issues then hold, head stays 11
        do_reset();
        pc = 8'h00; issues = 0; got.delete();
        for (int i = 0; i < 8; i++) begin
            run_cycle(1'b1, 1'b0);
            if (i >= 3) begin
                chk1($sformatf("bp_hold%0d_valid", i), instr_valid, 1'b1);
                chk8($sformatf("bp_hold%0d_instr", i), instr, 8'h11);
            end
        end
        chki("bp_issues", issues, 2);
        chk1("bp_stall", stall, 1'b1);
        chk8("bp_head_addr", instr_addr, 8'h00);
        for (int i = 0; i < 12; i++) begin
            run_cycle(pc < 8'h03, 1'b1);
        end
        chki("bp_count", got.size(), 3);
        if (got.size() == 3) begin
            chk8("bp_w0", got[0].d, 8'h11); chk8("bp_a0", got[0].a, 8'h00);
            chk8("bp_w1", got[1].d, 8'h22); chk8("bp_a1", got[1].a, 8'h01);
            chk8("bp_w2", got[2].d, 8'h33); chk8("bp_a2", got[2].a, 8'h02);
        end

        // Address wrap FE, FF, 00
        do_reset();
        pc = 8'hFE; issues = 0; got.delete();
        for (int i = 0; i < 16; i++) begin
            run_cycle(issues < 3, 1'b1);
        end
        chki("wrap_count", got.size(), 3);
        if (got.size() == 3) begin
            chk8("wrap_w0", got[0].d, 8'hA1); chk8("wrap_a0", got[0].a, 8'hFE);
            chk8("wrap_w1", got[1].d, 8'hB2); chk8("wrap_a1", got[1].a, 8'hFF);
            chk8("wrap_w2", got[2].d, 8'h11); chk8("wrap_a2", got[2].a, 8'h00);
        end

        // Asynchronous reset mid-stream, memory survives
        do_reset();
        pc = 8'h00; issues = 0; got.delete();
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b1, 1'b0);
        end
        chk1("arst_pre_valid", instr_valid, 1'b1);
        @(posedge clk);
        #3;
        power = 1'b0;
        #1;
        chk1("arst_valid", instr_valid, 1'b0);
        chk8("arst_instr", instr, 8'h00);
        chk8("arst_addr", instr_addr, 8'h00);
        chk1("arst_stall", stall, 1'b1);
        #1;
        power = 1'b1;
        pc = 8'h00; issues = 0; got.delete();
        for (int i = 0; i < 16; i++) begin
            run_cycle(issues < 1, 1'b1);
        end
        chki("arst_count", got.size(), 1);
        if (got.size() == 1) begin
            chk8("arst_w0", got[0].d, 8'h11);
            chk8("arst_a0", got[0].a, 8'h00);
        end

        // Flush with two words buffered, then fetch the rewritten word
        do_reset();
        pc = 8'h00; issues = 0; got.delete();
        for (int i = 0; i < 6; i++) begin
            run_cycle(1'b1, 1'b0);
        end
        chk1("fl_pre_stall", stall, 1'b1);
        chk1("fl_pre_valid", instr_valid, 1'b1);
        prog_we     = 1'b1;
        prog_addr   = 8'h00;
        prog_data   = 8'h5A;
        add_valid   = 1'b1;
        instr_ready = 1'b0;
        @(posedge clk);
        #1;
        prog_we = 1'b0;
        chk1("fl_valid", instr_valid, 1'b0);
        chk1("fl_stall", stall, 1'b1);
        pc = 8'h00; issues = 0; got.delete();
        for (int i = 0; i < 16; i++) begin
            run_cycle(issues < 1, 1'b1);
        end
        chki("fl_count", got.size(), 1);
        if (got.size() == 1) begin
            chk8("fl_w0", got[0].d, 8'h5A);
            chk8("fl_a0", got[0].a, 8'h00);
        end

`ifdef IFU_PARITY_EN
        // Corrupted parity bit: word still delivered, error sticky until reset
        do_reset();
        load(8'h05, 8'h07);
        dut.r_mem_par[5] = ~dut.r_mem_par[5];
        pc = 8'h05; issues = 0; got.delete();
        for (int i = 0; i < 10; i++) begin
            run_cycle(issues < 1, 1'b1);
        end
        chk1("par_set", par_err, 1'b1);
        chki("par_count", got.size(), 1);
        if (got.size() == 1) begin
            chk8("par_w0", got[0].d, 8'h07);
        end
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b0, 1'b1);
        end
        chk1("par_held", par_err, 1'b1);
        do_reset();
        chk1("par_cleared", par_err, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
